instr_fetch: RTL and testbench

Instruction fetch unit that produces the `instruction` / `instr_valid` / `pc` stream consumed by the decoder in the ID stage. It owns the fetch PC, issues in-order word reads to instruction memory, and buffers returned words with their PCs in a small FIFO. It discards stale fetches when execute/CSR logic redirects the PC (branch, jump, trap, mret).

---
 rtl/instr_fetch.sv | 148 ++++++++++++++
 tb/tb_instr_fetch.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit feeding the decoder.
// Owns the fetch PC, issues in-order word reads to instruction memory and
// buffers returned words together with their PCs in a small FIFO. A redirect
// flushes the FIFO and marks every still-outstanding read as stale, so those
// responses are dropped when they come back.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   imem_req_valid    read request valid (credit: inflight + count < DEPTH)
//   imem_req_ready    memory accepts the request this cycle
//   imem_addr         request address (always word aligned)
//   imem_rsp_valid    read data valid, responses in request order
//   imem_rsp_data     read data
//   instruction       FIFO head word, NOP bubble when empty
//   instr_valid       FIFO non-empty
//   pc                PC of head word, RESET_PC when empty
//   id_ready          decoder consumes the head word
//   redirect_valid    flush and restart fetch at redirect_pc
//   redirect_pc       new fetch PC (low two bits ignored)
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int              CW     = $clog2(DEPTH + 1);
    localparam int              PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0]     NOP    = 32'h0000_0013;
    localparam logic [CW:0]     CREDIT = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0]   FULL   = CW'(DEPTH);
    localparam logic [PW-1:0]   LAST   = PW'(DEPTH - 1);

    logic [31:0]   fetch_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_word [DEPTH];

    logic          accept;
    logic          rsp_take;
    logic          push;
    logic          pop;
    logic [CW-1:0] inflight_next;
    logic [31:0]   rsp_pc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Credit covers both outstanding reads and buffered words, so the FIFO
    // can never overflow. Depends only on registered state and rst.
    assign imem_req_valid = !rst && (({1'b0, inflight} + {1'b0, count}) < CREDIT);
    assign imem_addr      = fetch_pc;

    assign accept   = imem_req_valid && imem_req_ready;
    assign rsp_take = imem_rsp_valid && !rst;

    // Once drop reaches zero every outstanding read belongs to the current
    // fetch stream, which is contiguous up to fetch_pc, so the oldest one was
    // issued at fetch_pc - 4*inflight (mod 2^32).
    assign rsp_pc = fetch_pc - (32'(inflight) << 2);
    assign push   = rsp_take && (drop == '0) && !redirect_valid;

    assign instr_valid = (count != '0);
    assign pop         = instr_valid && id_ready;
    assign instruction = instr_valid ? fifo_word[rd_ptr] : NOP;
    assign pc          = instr_valid ? fifo_pc[rd_ptr]   : RESET_PC;

    always_comb begin
        inflight_next = inflight;
        if (accept) begin
            inflight_next = inflight_next + CW'(1);
        end
        if (rsp_take) begin
            inflight_next = inflight_next - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= inflight_next;
            if (redirect_valid) begin
                // Everything still outstanding after this cycle, including a
                // read accepted right now at the old address, is stale.
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                drop     <= inflight_next;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp_take && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
                if (push) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= rsp_pc;
            fifo_word[wr_ptr] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && (count == FULL)));
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instruction    (instruction),
        .instr_valid    (instr_valid),
        .pc             (pc),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];        // memory model: accepted reads awaiting response
    logic [31:0] exp_pc_q[$];  // scoreboard: PCs the decoder must see, in order
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          pops  = 0;
    int          lat_min   = 1;
    int          lat_max   = 1;
    int          ready_pct = 100;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic push_block(input logic [31:0] start);
        for (int i = 0; i < 64; i++) begin
            exp_pc_q.push_back(start + 32'(i * 4));
        end
    endtask

    // One clock cycle: check consumption, advance the clock, update the
    // memory model and drive its outputs for the next cycle.
    task automatic tick();
        logic        fire;
        logic        rsp;
        logic [31:0] a;
        logic [31:0] e_pc;
        mreq_t       e;
        #1;
        fire = imem_req_valid && imem_req_ready;
        a    = imem_addr;
        rsp  = imem_rsp_valid;
        if (!instr_valid) begin
            total++;
            if (instruction !== NOP) begin
                bad++;
                $display("FAIL bubble: instruction=%h required=%h", instruction, NOP);
            end
        end
        if (!rst && instr_valid && id_ready) begin
            pops++;
            total++;
            if (exp_pc_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty: popped pc=%h with nothing expected", pc);
            end else begin
                e_pc = exp_pc_q.pop_front();
                if (pc !== e_pc || instruction !== mem_word(e_pc)) begin
                    bad++;
                    $display("FAIL order: pc=%h instr=%h required pc=%h instr=%h",
                             pc, instruction, e_pc, mem_word(e_pc));
                end
            end
        end
        @(posedge clk);
        cyc++;
        if (rst) begin
            mq.delete();
        end else begin
            if (rsp && mq.size() > 0) begin
                e = mq.pop_front();
            end
            if (fire) begin
                e.addr = a;
                e.due  = cyc + int'($urandom_range(lat_min, lat_max)) - 1;
                mq.push_back(e);
            end
            if (redirect_valid) begin
                exp_pc_q.delete();
                push_block({redirect_pc[31:2], 2'b00});
            end
        end
        #1;
        imem_req_ready = (int'($urandom_range(0, 99)) < ready_pct);
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    // Holds reset for four edges, with junk responses offered meanwhile.
    task automatic reset_hold();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b1;
        repeat (3) begin
            tick();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
        tick();
    endtask

    task automatic reset_release();
        exp_pc_q.delete();
        push_block(RESET_PC);
        rst  = 1'b0;
        pops = 0;
        #1;
    endtask

    task automatic test_reset();
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        lat_min = 1; lat_max = 1; ready_pct = 100;
        reset_hold();
        #1;
        total++;
        if (imem_req_valid !== 1'b0) begin
            bad++; $display("FAIL reset_req_valid: got=%b required=0", imem_req_valid);
        end
        total++;
        if (imem_addr !== RESET_PC) begin
            bad++; $display("FAIL reset_addr: got=%h required=%h", imem_addr, RESET_PC);
        end
        total++;
        if (instr_valid !== 1'b0 || instruction !== NOP || pc !== RESET_PC) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b instr=%h pc=%h required 0/%h/%h",
                     instr_valid, instruction, pc, NOP, RESET_PC);
        end
        reset_release();
        total++;
        if (imem_req_valid !== 1'b1 || imem_addr !== RESET_PC) begin
            bad++;
            $display("FAIL first_request: valid=%b addr=%h required 1/%h",
                     imem_req_valid, imem_addr, RESET_PC);
        end
    endtask

    // The credit counts buffered words as well as outstanding reads, so with
    // DEPTH=2 and a 1-cycle memory the stream delivers two words every three
    // cycles: pops at cycles 2,3, 5,6, 8,9, ...
    task automatic test_stream();
        reset_hold();
        lat_min = 1; lat_max = 1; ready_pct = 100;
        reset_release();
        for (int k = 0; k <= 20; k++) begin
            if (k == 1) begin
                total++;
                if (instr_valid !== 1'b0) begin
                    bad++; $display("FAIL stream_early_valid: got=%b required=0", instr_valid);
                end
            end
            if (k == 2) begin
                total++;
                if (instr_valid !== 1'b1 || pc !== RESET_PC) begin
                    bad++;
                    $display("FAIL stream_first: valid=%b pc=%h required 1/%h",
                             instr_valid, pc, RESET_PC);
                end
            end
            tick();
        end
        total++;
        if (pops != 13) begin
            bad++; $display("FAIL stream_rate: pops=%0d required=13", pops);
        end
    endtask

    task automatic test_stall();
        reset_hold();
        total++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL midstream_reset: valid=%b req=%b required 0/0",
                     instr_valid, imem_req_valid);
        end
        lat_min = 1; lat_max = 1; ready_pct = 100;
        reset_release();
        id_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k >= 2) begin
                total++;
                if (imem_req_valid !== 1'b0 || instr_valid !== 1'b1 || pc !== RESET_PC) begin
                    bad++;
                    $display("FAIL stall_hold: req=%b valid=%b pc=%h required 0/1/%h",
                             imem_req_valid, instr_valid, pc, RESET_PC);
                end
            end
            tick();
        end
        id_ready = 1'b1;
        pops = 0;
        repeat (20) tick();
        total++;
        if (pops < 10) begin
            bad++; $display("FAIL stall_release: pops=%0d required>=10", pops);
        end
    endtask

    // Two reads outstanding at the redirect; the first stale response lands
    // in the redirect cycle itself, the second one a cycle later.
    task automatic test_redirect_inflight();
        reset_hold();
        lat_min = 2; lat_max = 2; ready_pct = 100;
        reset_release();
        tick();
        tick();
        lat_min = 1; lat_max = 1;
        total++;
        if (imem_req_valid !== 1'b0) begin
            bad++; $display("FAIL two_inflight: req=%b required=0", imem_req_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        total++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0000_0100) begin
            bad++;
            $display("FAIL redirect_req: req=%b addr=%h required 1/00000100",
                     imem_req_valid, imem_addr);
        end
        for (int k = 1; k <= 2; k++) begin
            total++;
            if (instr_valid !== 1'b0) begin
                bad++; $display("FAIL redirect_stale: R+%0d valid=%b pc=%h required 0", k, instr_valid, pc);
            end
            tick();
        end
        total++;
        if (instr_valid !== 1'b1 || pc !== 32'h0000_0100) begin
            bad++;
            $display("FAIL redirect_first: valid=%b pc=%h required 1/00000100", instr_valid, pc);
        end
        repeat (15) tick();
    endtask

    task automatic test_wrap();
        reset_hold();
        lat_min = 1; lat_max = 1; ready_pct = 100;
        reset_release();
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        total++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL wrap_addr0: req=%b addr=%h required 1/fffffffc", imem_req_valid, imem_addr);
        end
        tick();
        total++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0000_0000) begin
            bad++;
            $display("FAIL wrap_addr1: req=%b addr=%h required 1/00000000", imem_req_valid, imem_addr);
        end
        tick();
        total++;
        if (instr_valid !== 1'b1 || pc !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL wrap_first: valid=%b pc=%h required 1/fffffffc", instr_valid, pc);
        end
        repeat (10) tick();
    endtask

    task automatic test_random();
        int since;
        reset_hold();
        lat_min = 1; lat_max = 4; ready_pct = 50;
        reset_release();
        since = 0;
        for (int k = 0; k < 800; k++) begin
            id_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0 || since > 60) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
                since          = 0;
            end else begin
                redirect_valid = 1'b0;
                since++;
            end
            tick();
        end
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        total++;
        if (pops < 30) begin
            bad++; $display("FAIL random_progress: pops=%0d required>=30", pops);
        end
        lat_min = 1; lat_max = 1; ready_pct = 100;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
